// File: rtl/chi_test_sequencer.sv
// Sequences one chi-squared goodness-of-fit run: kicks the chi unit, streams the
// observed bin counts from the histogram RAM to it, then grades its result against a threshold.
module chi_test_sequencer #(
    parameter int unsigned DOF     = 5,
    parameter int unsigned POPSIZE = 100,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned CW  = $clog2(POPSIZE) + 8,
    localparam int unsigned AW  = (DOF > 0) ? $clog2(DOF + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   threshold,
    output logic          busy,
    output logic          bin_rd_en,
    output logic [AW-1:0] bin_rd_addr,
    input  logic [CW-1:0] bin_rd_data,
    output logic          chi_calc_done,
    input  logic          chi_rd_rqst,
    output logic [CW-1:0] chi_O,
    output logic          chi_data_rdy,
    input  logic [31:0]   chi_out,
    input  logic          chi_data_vld,
    output logic          result_vld,
    output logic [31:0]   chi_result,
    output logic          pass,
    output logic          timeout_err
);
    localparam int unsigned IW = $clog2(DOF + 2);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DOF);
    localparam logic [IW-1:0] END_IDX  = IW'(DOF + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KICK, S_WAIT_RQ, S_FETCH, S_PRESENT, S_WAIT_VLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] bin_idx_q, bin_idx_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [31:0]   thr_q, thr_d;
    logic [31:0]   baseline_q, baseline_d;
    logic          busy_q, busy_d;
    logic          bin_rd_en_q, bin_rd_en_d;
    logic [AW-1:0] bin_rd_addr_q, bin_rd_addr_d;
    logic          chi_calc_done_q, chi_calc_done_d;
    logic [CW-1:0] chi_o_q, chi_o_d;
    logic          chi_data_rdy_q, chi_data_rdy_d;
    logic          result_vld_q, result_vld_d;
    logic [31:0]   chi_result_q, chi_result_d;
    logic          pass_q, pass_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   run_delta;
    logic          wdog_expired;

    // The chi unit never clears its accumulator, so the statistic is the growth since KICK.
    assign run_delta    = chi_out - baseline_q;
    assign wdog_expired = (wdog_q == WDOG_MAX);

    always_comb begin
        state_d         = state_q;
        bin_idx_d       = bin_idx_q;
        thr_d           = thr_q;
        baseline_d      = baseline_q;
        bin_rd_en_d     = 1'b0;
        bin_rd_addr_d   = bin_rd_addr_q;
        chi_calc_done_d = 1'b0;
        chi_o_d         = chi_o_q;
        chi_data_rdy_d  = 1'b0;
        result_vld_d    = 1'b0;
        chi_result_d    = chi_result_q;
        pass_d          = pass_q;
        timeout_err_d   = timeout_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d           = threshold;
                    timeout_err_d   = 1'b0;
                    bin_idx_d       = '0;
                    chi_calc_done_d = 1'b1;
                    state_d         = S_KICK;
                end
            end
            S_KICK: begin
                baseline_d = chi_out;
                state_d    = S_WAIT_RQ;
            end
            S_WAIT_RQ: begin
                // A final-result pulse only counts once every bin has gone out.
                if (chi_data_vld && bin_idx_q == END_IDX) begin
                    state_d = S_DONE;
                end else if (chi_rd_rqst) begin
                    if (bin_idx_q <= LAST_IDX) begin
                        bin_rd_en_d   = 1'b1;
                        bin_rd_addr_d = AW'(bin_idx_q);
                        state_d       = S_FETCH;
                    end else begin
                        state_d = S_WAIT_VLD;
                    end
                end else if (wdog_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_FETCH: state_d = S_PRESENT;
            S_PRESENT: begin
                chi_o_d        = bin_rd_data;
                chi_data_rdy_d = 1'b1;
                bin_idx_d      = bin_idx_q + 1'b1;
                state_d        = S_WAIT_RQ;
            end
            S_WAIT_VLD: begin
                if (chi_data_vld) begin
                    state_d = S_DONE;
                end else if (wdog_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_DONE: begin
                chi_result_d = run_delta;
                pass_d       = (run_delta <= thr_q);
                result_vld_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        if (state_d != state_q || !(state_q == S_WAIT_RQ || state_q == S_WAIT_VLD))
            wdog_d = '0;
        else
            wdog_d = wdog_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bin_idx_q       <= '0;
            wdog_q          <= '0;
            thr_q           <= '0;
            baseline_q      <= '0;
            busy_q          <= 1'b0;
            bin_rd_en_q     <= 1'b0;
            bin_rd_addr_q   <= '0;
            chi_calc_done_q <= 1'b0;
            chi_o_q         <= '0;
            chi_data_rdy_q  <= 1'b0;
            result_vld_q    <= 1'b0;
            chi_result_q    <= '0;
            pass_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            bin_idx_q       <= bin_idx_d;
            wdog_q          <= wdog_d;
            thr_q           <= thr_d;
            baseline_q      <= baseline_d;
            busy_q          <= busy_d;
            bin_rd_en_q     <= bin_rd_en_d;
            bin_rd_addr_q   <= bin_rd_addr_d;
            chi_calc_done_q <= chi_calc_done_d;
            chi_o_q         <= chi_o_d;
            chi_data_rdy_q  <= chi_data_rdy_d;
            result_vld_q    <= result_vld_d;
            chi_result_q    <= chi_result_d;
            pass_q          <= pass_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign busy          = busy_q;
    assign bin_rd_en     = bin_rd_en_q;
    assign bin_rd_addr   = bin_rd_addr_q;
    assign chi_calc_done = chi_calc_done_q;
    assign chi_O         = chi_o_q;
    assign chi_data_rdy  = chi_data_rdy_q;
    assign result_vld    = result_vld_q;
    assign chi_result    = chi_result_q;
    assign pass          = pass_q;
    assign timeout_err   = timeout_err_q;
endmodule
